// File: rtl/leaf_sched_pkg.sv
// Shared types and constants for the leaf crossbar scheduler.
package leaf_sched_pkg;

    localparam int         NUM_REQ  = 5;
    localparam logic [2:0] NO_GRANT = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_DOWN = 2'b01,
        DIR_UP   = 2'b10,
        DIR_LOOP = 2'b11
    } dir_t;

endpackage

// File: rtl/leaf_xbar_scheduler_if.sv
// Request/target-ready inputs and grant/direction outputs of the leaf crossbar scheduler.
interface leaf_xbar_scheduler_if;

    logic [4:0] req_valid;
    logic [5:0] gpu_dest_addr;
    logic       gpu_ready;
    logic [3:0] spine_ready;
    logic [4:0] grant;
    logic [2:0] current_grant;
    logic [1:0] direction;
    logic [1:0] up_port;
    logic       xfer;

    modport master (
        output req_valid, gpu_dest_addr, gpu_ready, spine_ready,
        input  grant, current_grant, direction, up_port, xfer
    );

    modport slave (
        input  req_valid, gpu_dest_addr, gpu_ready, spine_ready,
        output grant, current_grant, direction, up_port, xfer
    );

endinterface

// File: rtl/rr_pick5.sv
// Rotating-priority picker: first set request at or after ptr, searching upward modulo 5.
module rr_pick5
    import leaf_sched_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] winner,
    output logic [2:0] idx
);

    logic       found;
    logic [3:0] sum;
    logic [2:0] slot;

    always_comb begin
        winner = '0;
        idx    = NO_GRANT;
        found  = 1'b0;
        sum    = '0;
        slot   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + 4'(i);
            if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
            slot = sum[2:0];
            if (!found && req[slot]) begin
                found        = 1'b1;
                winner[slot] = 1'b1;
                idx          = slot;
            end
        end
    end

endmodule

// File: rtl/leaf_xbar_scheduler.sv
// Round-robin, burst-bounded scheduler for the shared leaf crossbar.
// Optional stall watchdog enabled by defining LEAF_SCHED_WDOG_EN.
module leaf_xbar_scheduler
    import leaf_sched_pkg::*;
#(
    parameter logic [3:0] GROUP_ID       = 4'b1000,
    parameter int         BURST_MAX      = 4,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arb_enable,
    leaf_xbar_scheduler_if.slave  bus,
    output logic                  busy,
    output logic                  timeout_err
);

    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst
        $error("BURST_MAX must be 1..15");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 2..255");
    end

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] beat_q, beat_d;
    logic [4:0] grant_q, grant_d;
    logic [2:0] cur_q, cur_d;
    dir_t       dir_q, dir_d;
    logic [1:0] up_q, up_d;
    logic       tout_q, tout_d;

    logic [4:0] pick_onehot;
    logic [2:0] pick_idx;
    logic       target_ready, req_held, xfer, last_beat, stall_hit;

    rr_pick5 u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    // Target selection comes from the direction latched at grant time, not live address.
    always_comb begin
        target_ready = 1'b0;
        case (dir_q)
            DIR_UP:             target_ready = bus.spine_ready[up_q];
            DIR_DOWN, DIR_LOOP: target_ready = bus.gpu_ready;
            default:            target_ready = 1'b0;
        endcase
    end

    assign req_held  = |(grant_q & bus.req_valid);
    assign xfer      = (state_q == GRANT) && req_held && target_ready;
    assign last_beat = xfer && ((beat_q + 4'd1) == 4'(BURST_MAX));

`ifdef LEAF_SCHED_WDOG_EN
    logic [7:0] stall_q, stall_d;

    always_comb begin
        stall_d   = '0;
        stall_hit = 1'b0;
        if (state_q == GRANT) begin
            stall_d = stall_q;
            if (xfer) begin
                stall_d = '0;
            end else if (req_held && !target_ready) begin
                stall_d   = stall_q + 8'd1;
                stall_hit = (stall_d == 8'(TIMEOUT_CYCLES));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        grant_d = grant_q;
        cur_d   = cur_q;
        dir_d   = dir_q;
        up_d    = up_q;
        tout_d  = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                state_d = IDLE;
                grant_d = '0;
                cur_d   = NO_GRANT;
                dir_d   = DIR_IDLE;
                if (arb_enable && (bus.req_valid != '0)) begin
                    state_d = GRANT;
                    grant_d = pick_onehot;
                    cur_d   = pick_idx;
                    beat_d  = '0;
                    if (pick_idx != 3'd0) begin
                        dir_d = DIR_DOWN;
                    end else if (bus.gpu_dest_addr[5:2] == GROUP_ID) begin
                        dir_d = DIR_LOOP;
                    end else begin
                        dir_d = DIR_UP;
                        up_d  = bus.gpu_dest_addr[1:0];
                    end
                end
            end
            GRANT: begin
                if (xfer) beat_d = beat_q + 4'd1;
                if (!req_held || last_beat || stall_hit) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    cur_d   = NO_GRANT;
                    dir_d   = DIR_IDLE;
                    ptr_d   = (cur_q == 3'd4) ? 3'd0 : cur_q + 3'd1;
                    tout_d  = stall_hit;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples the pre-edge values computed above.
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            beat_q  <= '0;
            grant_q <= '0;
            cur_q   <= NO_GRANT;
            dir_q   <= DIR_IDLE;
            up_q    <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            up_q    <= up_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.current_grant = cur_q;
    assign bus.direction     = dir_q;
    assign bus.up_port       = up_q;
    assign bus.xfer          = xfer;
    assign busy              = (state_q == GRANT);
    assign timeout_err       = tout_q;

endmodule

// File: tb/tb_leaf_xbar_scheduler.sv
// Directed bench for leaf_xbar_scheduler: beats checked by a scoreboard monitor, timing by direct checks.
module tb_leaf_xbar_scheduler;
    import leaf_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic arb_enable;
    logic busy;
    logic timeout_err;

    leaf_xbar_scheduler_if bus();

    leaf_xbar_scheduler #(
        .GROUP_ID       (4'b1000),
        .BURST_MAX      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arb_enable  (arb_enable),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic [1:0] dir;
        logic [1:0] up;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int n, input logic [2:0] idx, input logic [1:0] dir, input logic [1:0] up);
        repeat (n) exp_q.push_back(beat_t'{idx, dir, up});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        arb_enable        = 1'b1;
        bus.req_valid     = '0;
        bus.gpu_dest_addr = '0;
        bus.gpu_ready     = 1'b0;
        bus.spine_ready   = '0;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (2) cyc();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " grant"},         bus.grant, 5'b0);
        check({tag, " current_grant"}, bus.current_grant, 3'd7);
        check({tag, " direction"},     bus.direction, 2'b00);
        check({tag, " up_port"},       bus.up_port, 2'b00);
        check({tag, " busy"},          busy, 1'b0);
        check({tag, " timeout_err"},   timeout_err, 1'b0);
        check({tag, " xfer"},          bus.xfer, 1'b0);
    endtask

    // Scoreboard monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.xfer === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected beat: idx=%0d dir=%0b with empty scoreboard at %0t",
                         bus.current_grant, bus.direction, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat idx", bus.current_grant, mon_e.idx);
                check("beat dir", bus.direction, mon_e.dir);
                if (mon_e.dir == DIR_UP) check("beat up_port", bus.up_port, mon_e.up);
            end
        end
    end

    initial begin
        // Reset values
        do_reset();
        smp();
        check_reset_outputs("reset");

        // Single spine1 requester: 4 beats, 1 gap, regrant
        do_reset();
        bus.req_valid = 5'b00010;
        bus.gpu_ready = 1'b1;
        push(4, 3'd1, DIR_DOWN, 2'd0);
        smp();
        check("t1 grant before edge", bus.grant, 5'b0);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 6) bus.req_valid = '0;
            smp();
            if (c <= 4) begin
                check("t1 grant", bus.grant, 5'b00010);
                check("t1 xfer", bus.xfer, 1'b1);
                if (c == 1) check("t1 direction", bus.direction, 2'b01);
            end else if (c == 5) begin
                check("t1 release grant", bus.grant, 5'b0);
                check("t1 release busy", busy, 1'b0);
            end else begin
                check("t1 regrant", bus.grant, 5'b00010);
                check("t1 regrant no xfer", bus.xfer, 1'b0);
            end
        end
        drain("t1 beats outstanding");

        // All five requesters: order 0,1,2,3,4,0 with single-cycle gaps
        do_reset();
        bus.gpu_dest_addr = 6'b1000_00;
        bus.req_valid     = 5'b11111;
        bus.gpu_ready     = 1'b1;
        bus.spine_ready   = 4'hf;
        push(4, 3'd0, DIR_LOOP, 2'd0);
        for (int k = 1; k <= 4; k++) push(4, 3'(k), DIR_DOWN, 2'd0);
        push(4, 3'd0, DIR_LOOP, 2'd0);
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (c == 30) bus.req_valid = '0;
            smp();
            if (c % 5 == 0) check("t2 gap grant", bus.grant, 5'b0);
            else            check("t2 grant", bus.grant, 32'(1) << (((c - 1) / 5) % 5));
        end
        drain("t2 beats outstanding");

        // GPU loopback, then GPU up to spine2 gated only by spine_ready[2]
        do_reset();
        bus.gpu_dest_addr = 6'b1000_10;
        bus.req_valid     = 5'b00001;
        bus.gpu_ready     = 1'b1;
        push(4, 3'd0, DIR_LOOP, 2'd0);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 5) bus.req_valid = '0;
            smp();
            if (c == 1) check("t3 loop direction", bus.direction, 2'b11);
            if (c == 5) check("t3 loop release", bus.grant, 5'b0);
        end
        cyc();
        bus.gpu_dest_addr = 6'b0011_10;
        bus.req_valid     = 5'b00001;
        bus.spine_ready   = 4'b1011;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 2) bus.gpu_dest_addr = 6'b1000_00;
            if (c == 3) begin
                bus.spine_ready = 4'b0100;
                push(4, 3'd0, DIR_UP, 2'd2);
            end
            if (c == 7) bus.req_valid = '0;
            smp();
            if (c == 1) begin
                check("t3 up direction", bus.direction, 2'b10);
                check("t3 up_port", bus.up_port, 2'd2);
                check("t3 up stalled xfer", bus.xfer, 1'b0);
            end
            if (c == 2) begin
                check("t3 up stalled xfer 2", bus.xfer, 1'b0);
                check("t3 direction latched", bus.direction, 2'b10);
            end
            if (c == 3) check("t3 up xfer", bus.xfer, 1'b1);
            if (c == 7) check("t3 up release", bus.grant, 5'b0);
        end
        drain("t3 beats outstanding");

        // Spine3 stalled 5 cycles, then 4 beats
        do_reset();
        bus.req_valid   = 5'b01000;
        bus.spine_ready = 4'hf;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 6) begin
                bus.gpu_ready = 1'b1;
                push(4, 3'd3, DIR_DOWN, 2'd0);
            end
            if (c == 10) bus.req_valid = '0;
            smp();
            if (c <= 5) begin
                check("t4 stall grant held", bus.grant, 5'b01000);
                check("t4 stall no xfer", bus.xfer, 1'b0);
            end
            if (c == 9)  check("t4 last beat grant", bus.grant, 5'b01000);
            if (c == 10) check("t4 release", bus.grant, 5'b0);
        end
        drain("t4 beats outstanding");

        // Valid drop after 2 beats releases next cycle
        do_reset();
        bus.req_valid = 5'b00100;
        bus.gpu_ready = 1'b1;
        push(2, 3'd2, DIR_DOWN, 2'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 3) bus.req_valid = '0;
            smp();
            if (c == 3) begin
                check("t4b grant at drop", bus.grant, 5'b00100);
                check("t4b no xfer at drop", bus.xfer, 1'b0);
            end
            if (c == 4) begin
                check("t4b release grant", bus.grant, 5'b0);
                check("t4b release busy", busy, 1'b0);
            end
        end
        drain("t4b beats outstanding");

        // Stalled GPU-up grant: watchdog release or indefinite hold
        do_reset();
        bus.gpu_dest_addr = 6'b0011_01;
        bus.req_valid     = 5'b00001;
        bus.gpu_ready     = 1'b1;
        bus.spine_ready   = 4'b1101;
`ifdef LEAF_SCHED_WDOG_EN
        for (int c = 1; c <= 22; c++) begin
            cyc();
            if (c == 17) begin
                bus.req_valid = 5'b00011;
                push(4, 3'd1, DIR_DOWN, 2'd0);
            end
            if (c == 22) bus.req_valid = '0;
            smp();
            if (c <= 16) check("t5 no early timeout", timeout_err, 1'b0);
            if (c == 16) check("t5 grant held", bus.grant, 5'b00001);
            if (c == 17) begin
                check("t5 timeout pulse", timeout_err, 1'b1);
                check("t5 timeout release", bus.grant, 5'b0);
            end
            if (c == 18) begin
                check("t5 pointer advanced", bus.grant, 5'b00010);
                check("t5 pulse one cycle", timeout_err, 1'b0);
            end
            if (c == 22) check("t5 final release", bus.grant, 5'b0);
        end
`else
        for (int c = 1; c <= 22; c++) begin
            cyc();
            if (c == 21) bus.req_valid = '0;
            smp();
            if (c <= 20) check("t5 no timeout", timeout_err, 1'b0);
            if (c == 20) check("t5 grant held", bus.grant, 5'b00001);
            if (c == 21) check("t5 grant at drop", bus.grant, 5'b00001);
            if (c == 22) check("t5 release", bus.grant, 5'b0);
        end
`endif
        drain("t5 beats outstanding");

        // Reset mid-burst
        do_reset();
        bus.req_valid = 5'b10000;
        bus.gpu_ready = 1'b1;
        push(2, 3'd4, DIR_DOWN, 2'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 3) reset = 1'b1;
            if (c == 4) begin
                reset         = 1'b0;
                bus.req_valid = '0;
            end
            smp();
            if (c == 2) check("t6 grant before reset", bus.grant, 5'b10000);
            if (c == 4) check_reset_outputs("t6 mid-burst reset");
        end
        drain("t6 beats outstanding");

        // arb_enable gating new grants only
        do_reset();
        arb_enable    = 1'b0;
        bus.req_valid = 5'b00100;
        bus.gpu_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 4) begin
                arb_enable = 1'b1;
                push(4, 3'd2, DIR_DOWN, 2'd0);
            end
            if (c == 6)  arb_enable = 1'b0;
            if (c == 10) bus.req_valid = '0;
            smp();
            if (c <= 4) check("t7 disabled no grant", bus.grant, 5'b0);
            if (c == 5) check("t7 grant after enable", bus.grant, 5'b00100);
            if (c == 8) check("t7 burst completes", bus.grant, 5'b00100);
            if (c == 10) begin
                check("t7 no regrant", bus.grant, 5'b0);
                check("t7 idle busy", busy, 1'b0);
            end
        end
        drain("t7 beats outstanding");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
